// File: rtl/usbf_dma_svc.sv
// DMA service engine: round-robin grant over endpoint dma_req lines, moving one
// 32-bit word per grant between an endpoint's circular SSRAM buffer and the system stream.
module usbf_dma_svc #(
    parameter int unsigned NEP     = 4,
    parameter int unsigned AW      = 15,
    parameter int unsigned ACK_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NEP-1:0]    dma_req,
    output logic [NEP-1:0]    dma_ack,
    input  logic [NEP-1:0]    ep_in,
    input  logic [NEP*AW-1:0] ep_base,
    input  logic [NEP*12-1:0] ep_size,
    input  logic [NEP-1:0]    ep_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_adr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    input  logic              mem_ack,
    output logic              s_valid,
    output logic [31:0]       s_data,
    input  logic              s_ready,
    input  logic              i_valid,
    input  logic [31:0]       i_data,
    output logic              i_ready,
    output logic              busy
);

    localparam int unsigned EW    = (NEP > 1) ? $clog2(NEP) : 1;
    localparam logic [EW:0] NEP_W = (EW + 1)'(NEP);
    localparam logic [2:0]  GAP   = 3'(ACK_GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_MRD, S_SPUSH, S_IWAIT, S_MWR, S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   last_q, last_d;
    logic [EW-1:0]   gnt_q, gnt_d;
    logic [11:0]     ptr_q  [NEP];
    logic [11:0]     ptr_d  [NEP];
    logic [2:0]      hold_q [NEP];
    logic [2:0]      hold_d [NEP];

    logic [NEP-1:0]  dma_ack_q, dma_ack_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_adr_q, mem_adr_d;
    logic [31:0]     mem_dout_q, mem_dout_d;
    logic            s_valid_q, s_valid_d;
    logic [31:0]     s_data_q, s_data_d;
    logic            i_ready_q, i_ready_d;
    logic            busy_q, busy_d;

    logic [NEP-1:0]  elig;
    logic            found;
    logic [EW-1:0]   pick;
    logic [EW:0]     cand;

    always_comb begin
        for (int unsigned k = 0; k < NEP; k++) begin
            elig[k] = dma_req[k] && (hold_q[k] == 3'd0) && (ep_size[k*12 +: 12] != 12'd0);
        end
    end

    // Search starts one past the last grant and wraps modulo NEP.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = '0;
        for (int unsigned i = 1; i <= NEP; i++) begin
            cand = {1'b0, last_q} + (EW + 1)'(i);
            if (cand >= NEP_W) begin
                cand = cand - NEP_W;
            end
            if (!found && elig[cand[EW-1:0]]) begin
                found = 1'b1;
                pick  = cand[EW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        mem_adr_d  = mem_adr_q;
        mem_dout_d = mem_dout_q;
        s_data_d   = s_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d     = pick;
                    last_d    = pick;
                    mem_adr_d = ep_base[pick*AW +: AW] + AW'(ptr_q[pick]);
                    state_d   = ep_in[pick] ? S_IWAIT : S_MRD;
                end
            end
            S_MRD: begin
                if (mem_ack) begin
                    s_data_d = mem_din;
                    state_d  = S_SPUSH;
                end
            end
            S_SPUSH: if (s_ready) state_d = S_ACK;
            S_IWAIT: begin
                if (i_valid) begin
                    mem_dout_d = i_data;
                    state_d    = S_MWR;
                end
            end
            S_MWR:   if (mem_ack) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_req_d = (state_d == S_MRD) || (state_d == S_MWR);
        mem_we_d  = (state_d == S_MWR);
        s_valid_d = (state_d == S_SPUSH);
        i_ready_d = (state_d == S_IWAIT);
        busy_d    = (state_d != S_IDLE);
        for (int unsigned k = 0; k < NEP; k++) begin
            dma_ack_d[k] = (state_d == S_ACK) && (gnt_d == EW'(k));
        end
    end

    // ep_clr is applied last so it overrides the ACK-cycle pointer advance.
    always_comb begin
        for (int unsigned k = 0; k < NEP; k++) begin
            ptr_d[k]  = ptr_q[k];
            hold_d[k] = (hold_q[k] != 3'd0) ? hold_q[k] - 3'd1 : 3'd0;
            if ((state_q == S_ACK) && (gnt_q == EW'(k))) begin
                ptr_d[k]  = (ptr_q[k] + 12'd1 == ep_size[k*12 +: 12]) ? 12'd0 : ptr_q[k] + 12'd1;
                hold_d[k] = GAP;
            end
            if (ep_clr[k]) begin
                ptr_d[k]  = '0;
                hold_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= EW'(NEP - 1);
            gnt_q      <= '0;
            ptr_q      <= '{default: '0};
            hold_q     <= '{default: '0};
            dma_ack_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_dout_q <= '0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            i_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            dma_ack_q  <= dma_ack_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_dout_q <= mem_dout_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            i_ready_q  <= i_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign dma_ack  = dma_ack_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_adr  = mem_adr_q;
    assign mem_dout = mem_dout_q;
    assign s_valid  = s_valid_q;
    assign s_data   = s_data_q;
    assign i_ready  = i_ready_q;
    assign busy     = busy_q;

endmodule
